// File: rtl/port_uart_pkg.sv
// port_uart_pkg: shared FSM state, port bit indices and idle-line value for port_uart_tx.
// PORT_UART_TX_PARITY_EN adds the PARITY state.
package port_uart_pkg;
`ifdef PORT_UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
   localparam int STRB_BIT    = 0;
   localparam int FLUSH_BIT   = 1;
   localparam int CLR_OVF_BIT = 2;
   localparam int BUSY_BIT    = 0;
   localparam int FULL_BIT    = 1;
   localparam int EMPTY_BIT   = 2;
   localparam int OVF_BIT     = 3;
   localparam logic [7:0] IDLE_LINE = 8'hFF;
endpackage

// File: rtl/port_uart_tx_sync_fifo.sv
// sync_fifo: transmit byte FIFO with level flush and same-cycle push+pop when full.
module sync_fifo #(
   parameter int DEPTH = 4,
   parameter int W = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] mem [DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic wr, rd;
   assign rd = pop & ~empty & ~flush;
   assign wr = push & ~flush & (~full | rd);
   assign full = count == (AW+1)'(DEPTH);
   assign empty = count == '0;
   assign dout = mem[rptr];
   always_ff @(posedge clk) begin
      if (reset | flush) begin
         wptr <= '0;
         rptr <= '0;
         count <= '0;
      end else begin
         wptr <= wptr + AW'(wr);
         rptr <= rptr + AW'(rd);
         count <= count + (AW+1)'(wr) - (AW+1)'(rd);
      end
   end
   always_ff @(posedge clk)
      if (wr) mem[wptr] <= din;
endmodule

// File: rtl/port_uart_tx.sv
// port_uart_tx: port-mapped 8N1 serial transmitter with FIFO and status port.
// PORT_UART_TX_PARITY_EN switches frames to 8E1.
module port_uart_tx
   import port_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] data_in,
   input  logic [7:0] ctrl_in,
   output logic [7:0] status_out,
   output logic       tx
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
`ifdef PORT_UART_TX_PARITY_EN
   localparam state_t AFTER_DATA = PARITY;
   logic par, par_n;
`else
   localparam state_t AFTER_DATA = STOP;
`endif
   state_t state, state_n;
   logic [15:0] baud, baud_n;
   logic [2:0] bitcnt, bitcnt_n;
   logic [7:0] shift, shift_n, dout;
   logic [CW-1:0] count;
   logic full, empty, strobe_q, clr_q, ovf, ovf_n, push, pop, flush, drop, can_pop, last, tx_n;
   logic unused_ctrl;
   assign unused_ctrl = ^ctrl_in[7:3];
   assign push = ctrl_in[STRB_BIT] & ~strobe_q;
   assign flush = ctrl_in[FLUSH_BIT];
   assign can_pop = ~empty & ~flush;
   assign drop = push & ~flush & full & ~pop;
   assign last = baud == LAST;
   assign ovf_n = drop ? 1'b1 : (ctrl_in[CLR_OVF_BIT] & ~clr_q) ? 1'b0 : ovf;
   sync_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
      .clk(clk), .reset(reset), .push(push), .pop(pop), .flush(flush),
      .din(data_in), .dout(dout), .count(count), .full(full), .empty(empty)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         baud <= '0;
         bitcnt <= '0;
         shift <= IDLE_LINE;
         strobe_q <= 1'b0;
         clr_q <= 1'b0;
         ovf <= 1'b0;
         tx <= 1'b1;
`ifdef PORT_UART_TX_PARITY_EN
         par <= 1'b0;
`endif
      end else begin
         state <= state_n;
         baud <= baud_n;
         bitcnt <= bitcnt_n;
         shift <= shift_n;
         strobe_q <= ctrl_in[STRB_BIT];
         clr_q <= ctrl_in[CLR_OVF_BIT];
         ovf <= ovf_n;
         tx <= tx_n;
`ifdef PORT_UART_TX_PARITY_EN
         par <= par_n;
`endif
      end
   end
   // Every state change restarts the baud counter so bit edges stay frame-aligned.
   always_comb begin
      state_n = state;
      baud_n = last ? '0 : baud + 16'd1;
      bitcnt_n = bitcnt;
      shift_n = shift;
      pop = 1'b0;
`ifdef PORT_UART_TX_PARITY_EN
      par_n = par;
`endif
      case (state)
         IDLE: begin
            baud_n = '0;
            pop = can_pop;
         end
         START: state_n = last ? DATA : START;
         DATA: if (last) begin
            shift_n = shift >> 1;
            bitcnt_n = bitcnt + 3'd1;
            state_n = bitcnt == 3'd7 ? AFTER_DATA : DATA;
         end
`ifdef PORT_UART_TX_PARITY_EN
         PARITY: state_n = last ? STOP : PARITY;
`endif
         STOP: if (last) begin
            pop = can_pop;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      if (pop) begin
         state_n = START;
         shift_n = dout;
         bitcnt_n = '0;
`ifdef PORT_UART_TX_PARITY_EN
         par_n = ^dout;
`endif
      end
      tx_n = 1'b1;
      case (state_n)
         START: tx_n = 1'b0;
         DATA: tx_n = shift_n[0];
`ifdef PORT_UART_TX_PARITY_EN
         PARITY: tx_n = par_n;
`endif
         default: tx_n = 1'b1;
      endcase
   end
   always_comb begin
      status_out = '0;
      status_out[BUSY_BIT] = (state != IDLE) | (count != '0);
      status_out[FULL_BIT] = full;
      status_out[EMPTY_BIT] = empty;
      status_out[OVF_BIT] = ovf;
      status_out[7:4] = 4'(count);
   end
endmodule

// File: tb/tb_port_uart_tx.sv
// tb_port_uart_tx: scoreboard bench; a tx-line monitor decodes frames and checks them against queued bytes.
module tb_port_uart_tx;
   localparam int CPB = 4;
`ifdef PORT_UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   logic clk = 1'b0, reset = 1'b1, tx;
   logic [7:0] data_in = '0, ctrl_in = '0, status_out;
   int tests = 0, fails = 0, cyc = 0, off = -1, start_cyc = 0, last_end = -100, gap = 0, nframes = 0, n;
   bit mon_en = 1'b1;
   logic [7:0] sb[$];
   logic [10:0] rx, exp_f;

   port_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
      .clk(clk), .reset(reset), .data_in(data_in), .ctrl_in(ctrl_in),
      .status_out(status_out), .tx(tx)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic logic [10:0] frame_of(input logic [7:0] b);
`ifdef PORT_UART_TX_PARITY_EN
      return {1'b1, ^b, b, 1'b0};
`else
      return {1'b0, 1'b1, b, 1'b0};
`endif
   endfunction

   always @(negedge clk) begin
      if (!mon_en) off = -1;
      else if (off < 0) begin
         if (tx === 1'b0) begin
            off = 0;
            rx = '0;
            start_cyc = cyc;
            gap = cyc - last_end;
         end
      end else begin
         off++;
         if (off % CPB == CPB / 2) rx[off / CPB] = tx;
         if (off == CPB * NB - 1) begin
            nframes++;
            tests++;
            if (sb.size() == 0) begin
               fails++;
               $display("FAIL frame: unexpected frame bits %h, none queued", rx);
            end else begin
               exp_f = frame_of(sb.pop_front());
               if (rx !== exp_f) begin
                  fails++;
                  $display("FAIL frame: got bits %h expected %h", rx, exp_f);
               end
            end
            off = -1;
            last_end = cyc;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic sample;
      @(negedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b, input bit expect_tx);
      @(posedge clk);
      #1;
      data_in = b;
      ctrl_in = 8'h01;
      if (expect_tx) sb.push_back(b);
      @(posedge clk);
      #1;
      ctrl_in = 8'h00;
   endtask

   task automatic pulse(input logic [7:0] c);
      @(posedge clk);
      #1;
      ctrl_in = c;
      @(posedge clk);
      #1;
      ctrl_in = 8'h00;
   endtask

   task automatic wait_idle(input string name);
      int k = 0;
      while ((status_out[0] !== 1'b0 || off >= 0 || sb.size() != 0) && k < 2000) begin
         sample();
         k++;
      end
      check(name, 32'(k < 2000), 32'd1);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      sample();
      check("reset_tx", 32'(tx), 32'd1);
      check("reset_status", 32'(status_out), 32'h04);

      send(8'hA5, 1'b1);
      sample();
      check("push_status", 32'(status_out), 32'h11);
      check("latency_tx_high", 32'(tx), 32'd1);
      sample();
      check("latency_tx_low", 32'(tx), 32'd0);
      n = 0;
      while (status_out[0] === 1'b1 && n < 200) begin
         sample();
         n++;
      end
      check("frame_length", 32'(n), 32'(CPB * NB));
      check("single_idle_status", 32'(status_out), 32'h04);
      check("single_frames", 32'(nframes), 32'd1);

      send(8'h11, 1'b1);
      repeat (3) sample();
      for (int i = 0; i < 5; i++) send(8'h21 + 8'(i), i < 4);
      sample();
      check("overflow_status", 32'(status_out), 32'h4B);
      pulse(8'h04);
      sample();
      check("clr_ovf_status", 32'(status_out), 32'h43);
      wait_idle("overflow_drain");
      check("overflow_frames", 32'(nframes), 32'd6);
      check("overflow_idle_status", 32'(status_out), 32'h04);

      send(8'h00, 1'b1);
      send(8'hFF, 1'b1);
      wait_idle("b2b_drain");
      check("b2b_gap", 32'(gap), 32'd1);
      check("b2b_frames", 32'(nframes), 32'd8);

      for (int i = 0; i < 4; i++) send(8'h41 + 8'(i), i == 0);
      n = 0;
      while (off < 9 && n < 100) begin
         sample();
         n++;
      end
      check("flush_reach_data", 32'(n < 100), 32'd1);
      pulse(8'h02);
      sample();
      check("flush_status", 32'(status_out), 32'h05);
      wait_idle("flush_drain");
      repeat (20) sample();
      check("flush_frames", 32'(nframes), 32'd9);
      check("flush_tx", 32'(tx), 32'd1);
      check("flush_idle_status", 32'(status_out), 32'h04);

      send(8'h5A, 1'b1);
      n = 0;
      while (off != 17 && n < 100) begin
         sample();
         n++;
      end
      check("reset_mid_reach", 32'(n < 100), 32'd1);
      @(posedge clk);
      #1;
      mon_en = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      sb.delete();
      sample();
      check("reset_mid_tx", 32'(tx), 32'd1);
      check("reset_mid_status", 32'(status_out), 32'h04);
      mon_en = 1'b1;
      n = 0;
      for (int i = 0; i < 60; i++) begin
         sample();
         if (tx !== 1'b1) n++;
      end
      check("reset_mid_quiet", 32'(n), 32'd0);
      check("reset_mid_final_status", 32'(status_out), 32'h04);
      check("total_frames", 32'(nframes), 32'd9);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
